// File: rtl/flit_credit_sender.sv
//==============================================================================
// flit_credit_sender - FIFO-buffered, per-VC credit-gated flit injector. Rev 1.0
// Optional macro FLIT_SENDER_STALL_CNT_EN builds the credit-stall cycle counter.
//==============================================================================
`default_nettype none

module flit_credit_sender #(
  parameter int FLIT_WIDTH     = 38,
  parameter int DEST_BITS      = 2,
  parameter int VC_BITS        = 1,
  parameter int CREDITS_PER_VC = 4,
  parameter int DEPTH          = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [FLIT_WIDTH-1:0] put_flit,
  input  logic                  put_flit_valid,
  output logic                  put_flit_ready,
  output logic [FLIT_WIDTH-1:0] send_ports_putFlit_flit_in,
  output logic                  EN_send_ports_putFlit,
  input  logic [VC_BITS:0]      send_ports_getCredits,
  output logic                  EN_send_ports_getCredits,
  output logic                  credit_overflow,
  output logic [31:0]           stall_cycles
);

  localparam int NUM_VCS = 2 ** VC_BITS;
  localparam int CW      = $clog2(CREDITS_PER_VC + 1);
  localparam int AW      = $clog2(DEPTH);
  localparam int VC_LSB  = FLIT_WIDTH - 2 - DEST_BITS - VC_BITS;

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS_PER_VC);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);

  // Input FIFO storage and pointers (one extra wrap bit each)
  logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  ready_q, ready_d;
  logic                  gc_en_q;

  logic [CW-1:0]         credit_q [NUM_VCS];
  logic [CW-1:0]         credit_d [NUM_VCS];
  logic                  ovf_q, ovf_d;

  logic                  w_empty;
  logic                  w_full_d;
  logic                  w_push;
  logic                  w_inject;
  logic [FLIT_WIDTH-1:0] w_wr_data;
  logic [FLIT_WIDTH-1:0] w_head;
  logic [VC_BITS-1:0]    w_head_vc;
  logic                  w_ret_valid;
  logic [VC_BITS-1:0]    w_ret_vc;
  logic [NUM_VCS-1:0]    w_inc;
  logic [NUM_VCS-1:0]    w_dec;

  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_head    = mem_q[rd_ptr_q[AW-1:0]];
  assign w_head_vc = w_head[VC_LSB +: VC_BITS];

  assign w_push   = put_flit_valid && ready_q;
  assign w_inject = !w_empty && (credit_q[w_head_vc] != '0) && RST_N;

  always_comb begin
    w_wr_data                 = put_flit;
    w_wr_data[FLIT_WIDTH-1]   = 1'b1;
  end

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(w_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(w_inject);
  assign w_full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  assign ready_d  = !w_full_d;

  // Credit returns are only honoured once the poll enable is up
  assign w_ret_valid = send_ports_getCredits[VC_BITS] && gc_en_q;
  assign w_ret_vc    = send_ports_getCredits[VC_BITS-1:0];

  always_comb begin
    w_inc           = '0;
    w_dec           = '0;
    w_inc[w_ret_vc] = w_ret_valid;
    w_dec[w_head_vc] = w_inject;
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int v = 0; v < NUM_VCS; v++) begin
      credit_d[v] = credit_q[v];
      if (w_dec[v] && !w_inc[v]) begin
        credit_d[v] = credit_q[v] - CRED_ONE;
      end else if (w_inc[v] && !w_dec[v]) begin
        if (credit_q[v] == CRED_MAX) begin
          ovf_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + CRED_ONE;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
      gc_en_q  <= 1'b0;
      ovf_q    <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) begin
        credit_q[v] <= CRED_MAX;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      gc_en_q  <= 1'b1;
      ovf_q    <= ovf_d;
      for (int v = 0; v < NUM_VCS; v++) begin
        credit_q[v] <= credit_d[v];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= w_wr_data;
    end
  end

`ifdef FLIT_SENDER_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        w_stalled;

  assign w_stalled = !w_empty && (credit_q[w_head_vc] == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_q <= '0;
    end else if (w_stalled && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign put_flit_ready             = ready_q;
  assign EN_send_ports_getCredits   = gc_en_q;
  assign credit_overflow            = ovf_q;
  assign EN_send_ports_putFlit      = w_inject;
  assign send_ports_putFlit_flit_in = w_inject ? w_head : '0;

endmodule

`default_nettype wire

// File: tb/tb_flit_credit_sender.sv
//==============================================================================
// tb_flit_credit_sender - directed bench for flit_credit_sender. Rev 1.0
//==============================================================================
`default_nettype none

module tb_flit_credit_sender;

  localparam int FW = 38;

`ifdef FLIT_SENDER_STALL_CNT_EN
  localparam int STALL_ON = 1;
`else
  localparam int STALL_ON = 0;
`endif

  logic          CLK;
  logic          RST_N;
  logic [FW-1:0] put_flit;
  logic          put_flit_valid;
  logic          put_flit_ready;
  logic [FW-1:0] send_ports_putFlit_flit_in;
  logic          EN_send_ports_putFlit;
  logic [1:0]    send_ports_getCredits;
  logic          EN_send_ports_getCredits;
  logic          credit_overflow;
  logic [31:0]   stall_cycles;

  flit_credit_sender #(
    .FLIT_WIDTH(FW), .DEST_BITS(2), .VC_BITS(1), .CREDITS_PER_VC(4), .DEPTH(4)
  ) dut (
    .CLK                        (CLK),
    .RST_N                      (RST_N),
    .put_flit                   (put_flit),
    .put_flit_valid             (put_flit_valid),
    .put_flit_ready             (put_flit_ready),
    .send_ports_putFlit_flit_in (send_ports_putFlit_flit_in),
    .EN_send_ports_putFlit      (EN_send_ports_putFlit),
    .send_ports_getCredits      (send_ports_getCredits),
    .EN_send_ports_getCredits   (EN_send_ports_getCredits),
    .credit_overflow            (credit_overflow),
    .stall_cycles               (stall_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic          v;
    logic [FW-1:0] f;
    logic [1:0]    c;
    logic          e_rdy;
    logic          e_en;
    logic [FW-1:0] e_out;
    logic          e_gc;
  } vec_t;

  vec_t          tbl [10];
  logic [FW-1:0] push_q [$];
  logic [FW-1:0] got_q  [$];
  logic [FW-1:0] exp_q  [$];
  logic [FW-1:0] fl [6];
  logic [FW-1:0] g  [6];
  logic [FW-1:0] h  [5];
  logic [FW-1:0] j  [5];
  logic [FW-1:0] k  [4];
  logic [FW-1:0] fa, fb, fc, fd, fe;
  logic [31:0]   s0, s1, s2, s3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bridge-side flit: valid bit clear, tail = payload lsb, dst = 1
  function automatic logic [FW-1:0] mk(input logic vc, input logic [15:0] p);
    logic [FW-1:0] f;
    f              = '0;
    f[FW-2]        = p[0];
    f[FW-3 -: 2]   = 2'b01;
    f[FW-5]        = vc;
    f[15:0]        = p;
    return f;
  endfunction

  function automatic logic [FW-1:0] vv(input logic [FW-1:0] f);
    logic [FW-1:0] r;
    r        = f;
    r[FW-1]  = 1'b1;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [FW-1:0] f, input logic [1:0] c);
    put_flit_valid        = v;
    put_flit              = f;
    send_ports_getCredits = c;
    @(negedge CLK);
  endtask

  // Push queued flits honouring ready, return credits for the first n_ret cycles
  task automatic run_stream(input int cycles, input int n_ret, input logic [1:0] rw);
    int rets = n_ret;
    for (int i = 0; i < cycles; i++) begin
      if (EN_send_ports_putFlit) got_q.push_back(send_ports_putFlit_flit_in);
      if (push_q.size() > 0) begin
        put_flit_valid = 1'b1;
        put_flit       = push_q[0];
        if (put_flit_ready) void'(push_q.pop_front());
      end else begin
        put_flit_valid = 1'b0;
        put_flit       = '0;
      end
      send_ports_getCredits = (rets > 0) ? rw : 2'b00;
      if (rets > 0) rets--;
      @(negedge CLK);
    end
    put_flit_valid        = 1'b0;
    put_flit              = '0;
    send_ports_getCredits = 2'b00;
  endtask

  task automatic check_stream(input string name);
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_%0d", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST_N                 = 1'b0;
    put_flit_valid        = 1'b0;
    put_flit              = '0;
    send_ports_getCredits = 2'b00;

    for (int i = 0; i < 6; i++) begin
      fl[i] = mk(1'b0, 16'(16'h10 + i));
      g[i]  = mk(1'b0, 16'(16'h300 + i));
    end
    for (int i = 0; i < 5; i++) begin
      h[i] = mk(1'b1, 16'(16'h400 + i));
      j[i] = mk(1'b0, 16'(16'h500 + i));
    end
    for (int i = 0; i < 4; i++) k[i] = mk(1'b1, 16'(16'h600 + i));
    fa = mk(1'b0, 16'h100);
    fb = mk(1'b1, 16'h101);
    fc = mk(1'b0, 16'h200);
    fd = mk(1'b0, 16'h201);
    fe = mk(1'b0, 16'h202);

    // v, flit, credit | ready, en_put, flit_out, en_getCredits
    tbl[0] = '{1'b1, mk(1'b0, 16'hBAD), 2'b00, 1'b0, 1'b0, '0,        1'b0};
    tbl[1] = '{1'b1, fl[1],             2'b00, 1'b1, 1'b0, '0,        1'b1};
    tbl[2] = '{1'b1, fl[2],             2'b00, 1'b1, 1'b1, vv(fl[1]), 1'b1};
    tbl[3] = '{1'b1, fl[3],             2'b00, 1'b1, 1'b1, vv(fl[2]), 1'b1};
    tbl[4] = '{1'b1, fl[4],             2'b00, 1'b1, 1'b1, vv(fl[3]), 1'b1};
    tbl[5] = '{1'b1, fl[5],             2'b00, 1'b1, 1'b1, vv(fl[4]), 1'b1};
    tbl[6] = '{1'b0, '0,                2'b00, 1'b1, 1'b0, '0,        1'b1};
    tbl[7] = '{1'b0, '0,                2'b10, 1'b1, 1'b0, '0,        1'b1};
    tbl[8] = '{1'b0, '0,                2'b00, 1'b1, 1'b1, vv(fl[5]), 1'b1};
    tbl[9] = '{1'b0, '0,                2'b00, 1'b1, 1'b0, '0,        1'b1};

    repeat (2) @(negedge CLK);
    chk("rst_ready", put_flit_ready, 0);
    chk("rst_en_put", EN_send_ports_putFlit, 0);
    chk("rst_flit_out", send_ports_putFlit_flit_in, 0);
    chk("rst_en_gc", EN_send_ports_getCredits, 0);
    chk("rst_ovf", credit_overflow, 0);
    chk("rst_stall", stall_cycles, 0);

    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d_ready", i), put_flit_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_en_put", i), EN_send_ports_putFlit, tbl[i].e_en);
      chk($sformatf("vec%0d_flit_out", i), send_ports_putFlit_flit_in, tbl[i].e_out);
      chk($sformatf("vec%0d_en_gc", i), EN_send_ports_getCredits, tbl[i].e_gc);
      chk($sformatf("vec%0d_ovf", i), credit_overflow, 0);
      drive(tbl[i].v, tbl[i].f, tbl[i].c);
    end

    // Head-of-line: VC1 flit waits behind a credit-less VC0 head
    drive(1'b1, fa, 2'b00);
    chk("hol_a_blocked", EN_send_ports_putFlit, 0);
    drive(1'b1, fb, 2'b00);
    chk("hol_b_blocked", EN_send_ports_putFlit, 0);
    chk("hol_b_out_zero", send_ports_putFlit_flit_in, 0);
    drive(1'b0, '0, 2'b10);
    chk("hol_a_en", EN_send_ports_putFlit, 1);
    chk("hol_a_out", send_ports_putFlit_flit_in, vv(fa));
    drive(1'b0, '0, 2'b00);
    chk("hol_b_en", EN_send_ports_putFlit, 1);
    chk("hol_b_out", send_ports_putFlit_flit_in, vv(fb));
    drive(1'b0, '0, 2'b00);
    chk("hol_idle", EN_send_ports_putFlit, 0);

    // Same-cycle inject and return on VC0 leaves its counter at 1
    drive(1'b1, fc, 2'b10);
    chk("neut_c_out", send_ports_putFlit_flit_in, vv(fc));
    drive(1'b0, '0, 2'b10);
    chk("neut_empty", EN_send_ports_putFlit, 0);
    drive(1'b1, fd, 2'b00);
    chk("neut_d_out", send_ports_putFlit_flit_in, vv(fd));
    drive(1'b0, '0, 2'b00);
    drive(1'b1, fe, 2'b00);
    chk("neut_e_blocked", EN_send_ports_putFlit, 0);
    drive(1'b0, '0, 2'b10);
    chk("neut_e_out", send_ports_putFlit_flit_in, vv(fe));
    drive(1'b0, '0, 2'b00);
    chk("neut_ovf", credit_overflow, 0);

    // FIFO full with no VC0 credits
    drive(1'b1, g[0], 2'b00);
    chk("full_rdy0", put_flit_ready, 1);
    drive(1'b1, g[1], 2'b00);
    chk("full_rdy1", put_flit_ready, 1);
    drive(1'b1, g[2], 2'b00);
    chk("full_rdy2", put_flit_ready, 1);
    drive(1'b1, g[3], 2'b00);
    chk("full_rdy3", put_flit_ready, 0);
    drive(1'b1, g[4], 2'b00);
    chk("full_hold_rdy", put_flit_ready, 0);
    chk("full_hold_en", EN_send_ports_putFlit, 0);
    drive(1'b1, g[4], 2'b10);
    chk("full_g0_out", send_ports_putFlit_flit_in, vv(g[0]));
    chk("full_g0_rdy", put_flit_ready, 0);
    drive(1'b1, g[4], 2'b00);
    chk("full_rdy_back", put_flit_ready, 1);
    chk("full_no_credit", EN_send_ports_putFlit, 0);
    drive(1'b1, g[4], 2'b00);
    chk("full_again", put_flit_ready, 0);
    push_q.push_back(g[5]);
    for (int i = 1; i < 6; i++) exp_q.push_back(vv(g[i]));
    run_stream(20, 5, 2'b10);
    check_stream("full_order");
    chk("full_end_rdy", put_flit_ready, 1);
    chk("full_end_en", EN_send_ports_putFlit, 0);

    // Overflow on VC1 (3 credits held here)
    drive(1'b0, '0, 2'b11);
    chk("ovf_at_max", credit_overflow, 0);
    drive(1'b0, '0, 2'b11);
    chk("ovf_set", credit_overflow, 1);
    drive(1'b0, '0, 2'b00);
    chk("ovf_sticky", credit_overflow, 1);
    for (int i = 0; i < 5; i++) push_q.push_back(h[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(vv(h[i]));
    run_stream(16, 0, 2'b00);
    check_stream("ovf_sat");
    chk("ovf_sat_blocked", EN_send_ports_putFlit, 0);
    chk("ovf_still_set", credit_overflow, 1);

    // Asynchronous reset while a flit is being injected
    drive(1'b0, '0, 2'b11);
    chk("arst_pre_en", EN_send_ports_putFlit, 1);
    chk("arst_pre_out", send_ports_putFlit_flit_in, vv(h[4]));
    #2 RST_N = 1'b0;
    #1;
    chk("arst_en_put", EN_send_ports_putFlit, 0);
    chk("arst_flit_out", send_ports_putFlit_flit_in, 0);
    chk("arst_ready", put_flit_ready, 0);
    chk("arst_en_gc", EN_send_ports_getCredits, 0);
    chk("arst_ovf", credit_overflow, 0);
    chk("arst_stall", stall_cycles, 0);
    send_ports_getCredits = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    chk("arst_gc_low", EN_send_ports_getCredits, 0);
    @(posedge CLK);
    #1;
    chk("arst_gc_high", EN_send_ports_getCredits, 1);
    chk("arst_rdy_high", put_flit_ready, 1);
    @(negedge CLK);
    for (int i = 0; i < 4; i++) push_q.push_back(j[i]);
    for (int i = 0; i < 4; i++) push_q.push_back(k[i]);
    push_q.push_back(j[4]);
    for (int i = 0; i < 4; i++) exp_q.push_back(vv(j[i]));
    for (int i = 0; i < 4; i++) exp_q.push_back(vv(k[i]));
    run_stream(30, 0, 2'b00);
    check_stream("arst_credits");
    chk("arst_j4_blocked", EN_send_ports_putFlit, 0);
    chk("arst_ovf_clear", credit_overflow, 0);

    // Credit stall counter over a 10-cycle stall, then release
    s0 = stall_cycles;
    repeat (10) drive(1'b0, '0, 2'b00);
    s1 = stall_cycles;
    chk("stall_10", s1 - s0, (STALL_ON != 0) ? 10 : 0);
    drive(1'b0, '0, 2'b10);
    s2 = stall_cycles;
    chk("stall_release_en", EN_send_ports_putFlit, 1);
    chk("stall_release_out", send_ports_putFlit_flit_in, vv(j[4]));
    chk("stall_last", s2 - s1, (STALL_ON != 0) ? 1 : 0);
    drive(1'b0, '0, 2'b00);
    s3 = stall_cycles;
    chk("stall_no_count_inject", s3 - s2, 0);
    chk("stall_end_en", EN_send_ports_putFlit, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flit_credit_sender.md
Name: flit_credit_sender

Overview:
- Send-side injection stage between an AXI4 bridge's flit output (valid/ready) and one network send port (putFlit/getCredits).
- Buffers flits from the bridge in a small FIFO.
- Tracks per-VC downstream credits and injects a head flit only when its VC holds a credit.
- Returned credits replenish the counters; credit overflow is flagged as an error.

Parameters:
- FLIT_WIDTH, 38, total flit width including valid bit [FLIT_WIDTH-1].
- DEST_BITS, 2, destination field width.
- VC_BITS, 1, VC field width; NUM_VCS = 2**VC_BITS.
- CREDITS_PER_VC, 4, initial credits per VC (router input buffer depth).
- DEPTH, 4, input FIFO entries; power of two, at least 2.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- put_flit  in  FLIT_WIDTH  flit from bridge.
- put_flit_valid  in  1  upstream valid.
- put_flit_ready  out  1  FIFO not full.
- send_ports_putFlit_flit_in  out  FLIT_WIDTH  flit to network.
- EN_send_ports_putFlit  out  1  inject strobe.
- send_ports_getCredits  in  VC_BITS+1  credit return: [VC_BITS]=valid, [VC_BITS-1:0]=vc.
- EN_send_ports_getCredits  out  1  credit poll enable.
- credit_overflow  out  1  sticky error.
- stall_cycles  out  32  credit-stall counter (see optional feature).

Behaviour:
- Flit fields:
  - valid = [FW-1]; tail = [FW-2].
  - dst = [FW-3 -: DEST_BITS].
  - vc = [FW-3-DEST_BITS -: VC_BITS].
- Reset (RST_N low, asynchronous):
  - FIFO empty; all credit counters = CREDITS_PER_VC.
  - All outputs 0, including put_flit_ready, EN_send_ports_getCredits, credit_overflow and stall_cycles.
- EN_send_ports_getCredits: register, 0 in reset, 1 from the first clock edge after RST_N deasserts.
- Enqueue:
  - put_flit_ready = registered !full.
  - Accept on put_flit_valid && put_flit_ready.
  - The stored valid bit is forced to 1.
- Inject (combinational from state):
  - EN_send_ports_putFlit = !empty && credit[head.vc] != 0 && !rst_active.
  - flit_in = FIFO head when injecting, else all zeros.
  - On inject: pop and decrement credit[head.vc].
- Latency: a flit accepted at edge N can inject in the cycle after edge N (one-cycle minimum pass-through).
- Credit return: when send_ports_getCredits[VC_BITS]=1 and EN is high, increment credit[vc].
- Same VC inject and return in the same cycle: counter is unchanged.
- Counter width: $clog2(CREDITS_PER_VC+1).
- Overflow: a return on a VC at CREDITS_PER_VC (with no same-cycle inject on that VC) saturates the counter and sets credit_overflow. It stays set until reset.
- Full/empty:
  - Simultaneous enqueue and dequeue is allowed.
  - When full, ready deasserts and the next-cycle dequeue re-asserts it.
  - Pointers carry one extra wrap bit.
- Ordering: strict FIFO order, no overtaking. A blocked VC stalls all later flits (head-of-line), which preserves packet atomicity. Tail is not inspected for flow control.
- Reset mid-operation: FIFO contents discarded, counters restored, in-flight credits lost (the network is reset together).

Optional Feature:
- Macro FLIT_SENDER_STALL_CNT_EN.
- Defined: stall_cycles increments (saturating at 2^32-1) every cycle with !empty && credit[head.vc]==0.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Reset then push 4 flits on VC0 (CREDITS_PER_VC=4), no credits returned:
  - 4 injections on consecutive cycles, then EN_putFlit=0.
  - A 5th flit sits in the FIFO until a credit {1,0} returns.
  - It then injects the cycle after that return.
- Push flits alternating vc=0/vc=1 with VC0 credits exhausted: a VC1 flit queued behind a VC0 head is not sent (head-of-line block). One VC0 credit releases both on consecutive cycles.
- Credit-neutral same-cycle event: hold credit[0]=1, inject on VC0 while returning {1,0} the same cycle. Counter stays 1, no overflow.
- Overflow: with credit[1]=4 return {1,1} -> credit_overflow=1, counter stays 4, flag persists until RST_N pulse.
- FIFO full: hold the network with no credits and push DEPTH=4+2 flits:
  - ready drops after 4 accepts; no flit is lost or duplicated.
  - Injected order matches push order.
- Assert RST_N low mid-stream (asynchronous, between edges):
  - Outputs zero immediately; credits return to 4.
  - EN_getCredits rises one edge after deassert.
  - With FLIT_SENDER_STALL_CNT_EN, stall_cycles counts exactly 10 in a 10-cycle credit stall.
